// File: rtl/drive_pkg.sv
// Shared types and constants for the drive command sequencer.
// DRIVE_AUTO_BRAKE_EN adds the BRAKE state to the state encoding.
package drive_pkg;

  typedef enum logic [1:0] {
    FWD   = 2'b00,
    BACK  = 2'b01,
    LEFT  = 2'b10,
    RIGHT = 2'b11
  } instr_t;

  localparam logic [2:0] MAX_TORQUE   = 3'd4;
  localparam logic [2:0] BRAKE_TORQUE = 3'd2;
  localparam int         BRAKE_TICKS  = 4;

  typedef struct packed {
    instr_t     instr;
    logic [2:0] torque;
    logic [7:0] dur;
  } drive_cmd_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
`ifdef DRIVE_AUTO_BRAKE_EN
    S_RUN   = 2'd2,
    S_BRAKE = 2'd3
`else
    S_RUN   = 2'd2
`endif
  } state_t;

endpackage

// File: rtl/drive_cmd_sequencer_if.sv
// Command handshake between the command source and the drive sequencer.
interface drive_cmd_sequencer_if #(parameter int DUR_W = 8);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_instr;
  logic [2:0]       cmd_torque;
  logic [DUR_W-1:0] cmd_dur;

  modport master (output cmd_valid, cmd_instr, cmd_torque, cmd_dur, input cmd_ready);
  modport slave  (input cmd_valid, cmd_instr, cmd_torque, cmd_dur, output cmd_ready);
endinterface

// File: rtl/drive_cmd_fifo.sv
// Synchronous command FIFO with flush; DEPTH must be a power of two.
module drive_cmd_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  T              wdata,
  output T              rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // A full FIFO refuses a push even when it pops in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/drive_cmd_sequencer.sv
// Plays queued timed drive commands into the speed display block.
// Define DRIVE_AUTO_BRAKE_EN to add a reverse-torque brake phase when the queue runs dry.
//
// state   | meaning
// IDLE    | nothing playing, outputs 00/0
// LOAD    | pop head, latch instruction/torque/duration
// RUN     | command applied, one duration count per read_enable
// BRAKE   | (option) BACK at BRAKE_TORQUE for BRAKE_TICKS updates
module drive_cmd_sequencer
  import drive_pkg::*;
#(
  parameter int TICK_DIV = 5_000_000,
  parameter int DEPTH    = 4,
  parameter int DUR_W    = 8,
  localparam int CW      = $clog2(DEPTH + 1),
  localparam int TW      = $clog2(TICK_DIV)
) (
  input  logic                 clk,
  input  logic                 reset,
  drive_cmd_sequencer_if.slave cmd,
  input  logic                 abort,
  output logic [1:0]           instruction,
  output logic [2:0]           torque,
  output logic                 read_enable,
  output logic                 vel_reset,
  output logic                 busy,
  output logic                 done_pulse,
  output logic [CW-1:0]        cmd_count
);

  typedef struct packed {
    instr_t           instr;
    logic [2:0]       torque;
    logic [DUR_W-1:0] dur;
  } cmd_t;

  state_t           state, state_nxt, state_prev;
  logic [TW-1:0]    tick_cnt;
  logic             tick;
  logic [DUR_W-1:0] remaining;
  instr_t           instr_q;
  logic [2:0]       torque_q;
  cmd_t             wr_cmd, head;
  logic             push, pop, fifo_full, fifo_empty, active;

  assign cmd.cmd_ready = !fifo_full && !abort && reset;
  assign push          = cmd.cmd_valid && cmd.cmd_ready;
  assign wr_cmd.instr  = instr_t'(cmd.cmd_instr);
  assign wr_cmd.torque = (cmd.cmd_torque > MAX_TORQUE) ? MAX_TORQUE : cmd.cmd_torque;
  assign wr_cmd.dur    = cmd.cmd_dur;

  drive_cmd_fifo #(.T(cmd_t), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .flush(abort),
    .wdata(wr_cmd), .rdata(head), .full(fifo_full), .empty(fifo_empty), .count(cmd_count)
  );

  assign tick        = (tick_cnt == TW'(TICK_DIV - 1));
  assign busy        = (state != S_IDLE) || (cmd_count != '0);
  assign instruction = instr_q;
  assign torque      = torque_q;
`ifdef DRIVE_AUTO_BRAKE_EN
  assign active = (state == S_RUN) || (state == S_BRAKE);
`else
  assign active = (state == S_RUN);
`endif

  always_comb begin
    state_nxt  = state;
    done_pulse = 1'b0;
    pop        = 1'b0;
    case (state)
      S_IDLE: if (!fifo_empty) state_nxt = S_LOAD;
      S_LOAD: begin
        pop = 1'b1;
        if (head.dur == '0) begin
          done_pulse = 1'b1;
          state_nxt  = (cmd_count > CW'(1)) ? S_LOAD : S_IDLE;
        end else begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: if (read_enable && remaining == DUR_W'(1)) begin
        done_pulse = 1'b1;
        if (!fifo_empty) state_nxt = S_LOAD;
`ifdef DRIVE_AUTO_BRAKE_EN
        else             state_nxt = S_BRAKE;
`else
        else             state_nxt = S_IDLE;
`endif
      end
`ifdef DRIVE_AUTO_BRAKE_EN
      S_BRAKE: begin
        if (!fifo_empty)                                   state_nxt = S_LOAD;
        else if (read_enable && remaining == DUR_W'(1))    state_nxt = S_IDLE;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
    if (abort) begin
      state_nxt  = S_IDLE;
      pop        = 1'b0;
      done_pulse = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      state_prev  <= S_IDLE;
      tick_cnt    <= '0;
      read_enable <= 1'b0;
      vel_reset   <= 1'b1;
      remaining   <= '0;
      instr_q     <= FWD;
      torque_q    <= '0;
    end else begin
      state      <= state_nxt;
      state_prev <= state;
      tick_cnt   <= tick ? '0 : tick_cnt + TW'(1);
      // Skipping the first active cycle keeps instruction/torque settled 2 clk before the strobe.
      read_enable <= tick && active && (state_prev == state) && !abort;
      vel_reset   <= abort;
      if (abort || state_nxt == S_IDLE) begin
        instr_q   <= FWD;
        torque_q  <= '0;
        remaining <= '0;
      end else if (state == S_LOAD && state_nxt == S_RUN) begin
        instr_q   <= head.instr;
        torque_q  <= head.torque;
        remaining <= head.dur;
`ifdef DRIVE_AUTO_BRAKE_EN
      end else if (state == S_RUN && state_nxt == S_BRAKE) begin
        instr_q   <= BACK;
        torque_q  <= BRAKE_TORQUE;
        remaining <= DUR_W'(BRAKE_TICKS);
`endif
      end else if (read_enable && remaining != '0) begin
        remaining <= remaining - DUR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_drive_cmd_sequencer.sv
// Directed self-checking bench for drive_cmd_sequencer (TICK_DIV=4, DEPTH=4).
// Expectations follow DRIVE_AUTO_BRAKE_EN when the bench is built with it.
module tb_drive_cmd_sequencer;
  import drive_pkg::*;

  localparam int TICK_DIV = 4;
  localparam int DEPTH    = 4;
  localparam int DUR_W    = 8;
  localparam int CW       = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          abort = 1'b0;
  logic [1:0]    instruction;
  logic [2:0]    torque;
  logic          read_enable, vel_reset, busy, done_pulse;
  logic [CW-1:0] cmd_count;

  drive_cmd_sequencer_if #(.DUR_W(DUR_W)) cmd_if();

  drive_cmd_sequencer #(.TICK_DIV(TICK_DIV), .DEPTH(DEPTH), .DUR_W(DUR_W)) dut (
    .clk(clk), .reset(reset), .cmd(cmd_if), .abort(abort),
    .instruction(instruction), .torque(torque), .read_enable(read_enable),
    .vel_reset(vel_reset), .busy(busy), .done_pulse(done_pulse), .cmd_count(cmd_count)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         done_cnt, done_on_re, max_cnt, waited, gap;
  logic [4:0] re_log[$];
  logic [4:0] exp_log[$];
  int         re_stamp[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (read_enable) begin
      re_log.push_back({instruction, torque});
      re_stamp.push_back(cyc);
    end
    if (done_pulse) begin
      done_cnt++;
      if (read_enable) done_on_re++;
    end
    if (int'(cmd_count) > max_cnt) max_cnt = int'(cmd_count);
  endtask

  task automatic clear_mon();
    re_log.delete();
    exp_log.delete();
    re_stamp.delete();
    done_cnt = 0;
    done_on_re = 0;
    max_cnt = 0;
  endtask

  task automatic add_brake();
`ifdef DRIVE_AUTO_BRAKE_EN
    repeat (BRAKE_TICKS) exp_log.push_back({BACK, BRAKE_TORQUE});
`endif
  endtask

  task automatic push_cmd(input logic [1:0] i, input logic [2:0] t, input logic [7:0] d, output int w);
    cmd_if.cmd_instr  = i;
    cmd_if.cmd_torque = t;
    cmd_if.cmd_dur    = d;
    cmd_if.cmd_valid  = 1'b1;
    w = 0;
    while (!cmd_if.cmd_ready && w < 60) begin
      tick();
      w++;
    end
    chk("push_ready", cmd_if.cmd_ready, 1'b1);
    tick();
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int k = 0; k < budget && busy; k++) tick();
    chk(tag, busy, 1'b0);
  endtask

  task automatic wait_re(input string tag);
    for (int k = 0; k < 20 && !read_enable; k++) tick();
    chk(tag, read_enable, 1'b1);
  endtask

  task automatic check_log(input string tag);
    chk($sformatf("%s_len", tag), re_log.size(), exp_log.size());
    for (int i = 0; i < exp_log.size() && i < re_log.size(); i++)
      chk($sformatf("%s_re%0d", tag, i), re_log[i], exp_log[i]);
  endtask

  initial begin
    cmd_if.cmd_valid  = 1'b0;
    cmd_if.cmd_instr  = 2'b00;
    cmd_if.cmd_torque = 3'd0;
    cmd_if.cmd_dur    = '0;
    clear_mon();

    // reset held 3 clk
    repeat (3) tick();
    chk("rst_vel_reset", vel_reset, 1'b1);
    chk("rst_cmd_ready", cmd_if.cmd_ready, 1'b0);
    chk("rst_read_enable", read_enable, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cmd_count", cmd_count, 0);
    chk("rst_instr_torque", {instruction, torque}, 5'b0);
    chk("rst_done", done_pulse, 1'b0);
    reset = 1'b1;
    tick();
    chk("rel_vel_reset", vel_reset, 1'b0);
    chk("rel_cmd_ready", cmd_if.cmd_ready, 1'b1);
    clear_mon();
    repeat (10) tick();
    chk("idle_no_re", re_log.size(), 0);

    // single command FWD/3 for 2 ticks
    clear_mon();
    push_cmd(FWD, 3'd3, 8'd2, waited);
    wait_idle("t2_idle", 60);
    repeat (2) exp_log.push_back({FWD, 3'd3});
    add_brake();
    check_log("t2");
    gap = (re_stamp.size() >= 2) ? re_stamp[1] - re_stamp[0] : -1;
    chk("t2_gap", gap, 4);
    chk("t2_done", done_cnt, 1);
    chk("t2_done_on_re", done_on_re, 1);
    chk("t2_instr_idle", {instruction, torque}, 5'b0);

    // queue fill: A running, then B..F with F held
    clear_mon();
    push_cmd(FWD, 3'd1, 8'd3, waited);
    wait_re("t3_a_run");
    chk("t3_a_popped", cmd_count, 0);
    push_cmd(BACK,  3'd2, 8'd1, waited);
    push_cmd(LEFT,  3'd3, 8'd1, waited);
    push_cmd(RIGHT, 3'd4, 8'd1, waited);
    push_cmd(FWD,   3'd0, 8'd1, waited);
    chk("t3_count_full", cmd_count, 4);
    chk("t3_ready_full", cmd_if.cmd_ready, 1'b0);
    push_cmd(BACK, 3'd1, 8'd1, waited);
    chk("t3_fifth_held", waited > 0, 1'b1);
    wait_idle("t3_idle", 200);
    repeat (3) exp_log.push_back({FWD, 3'd1});
    exp_log.push_back({BACK, 3'd2});
    exp_log.push_back({LEFT, 3'd3});
    exp_log.push_back({RIGHT, 3'd4});
    exp_log.push_back({FWD, 3'd0});
    exp_log.push_back({BACK, 3'd1});
    add_brake();
    check_log("t3");
    chk("t3_done", done_cnt, 6);
    chk("t3_max_count", max_cnt, 4);

    // zero-duration skip and torque clamp
    clear_mon();
    push_cmd(LEFT,  3'd7, 8'd0, waited);
    push_cmd(RIGHT, 3'd1, 8'd1, waited);
    push_cmd(BACK,  3'd6, 8'd1, waited);
    wait_idle("t4_idle", 100);
    exp_log.push_back({RIGHT, 3'd1});
    exp_log.push_back({BACK, 3'd4});
    add_brake();
    check_log("t4");
    chk("t4_done", done_cnt, 3);
    chk("t4_done_on_re", done_on_re, 2);

    // abort mid-RUN with two queued and a simultaneous push
    clear_mon();
    push_cmd(FWD, 3'd2, 8'd5, waited);
    wait_re("t5_run");
    push_cmd(LEFT,  3'd1, 8'd1, waited);
    push_cmd(RIGHT, 3'd1, 8'd1, waited);
    chk("t5_queued", cmd_count, 2);
    cmd_if.cmd_instr  = BACK;
    cmd_if.cmd_torque = 3'd3;
    cmd_if.cmd_dur    = 8'd2;
    cmd_if.cmd_valid  = 1'b1;
    abort = 1'b1;
    #1;
    chk("t5_ready_abort", cmd_if.cmd_ready, 1'b0);
    tick();
    chk("t5_busy", busy, 1'b0);
    chk("t5_count", cmd_count, 0);
    chk("t5_instr_torque", {instruction, torque}, 5'b0);
    chk("t5_vel_reset_hi", vel_reset, 1'b1);
    chk("t5_no_re", read_enable, 1'b0);
    abort = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    tick();
    chk("t5_vel_reset_lo", vel_reset, 1'b0);
    chk("t5_dropped", cmd_count, 0);
    clear_mon();
    repeat (12) tick();
    chk("t5_quiet", re_log.size(), 0);

    // run-out behaviour: brake phase or coast
    clear_mon();
    push_cmd(FWD, 3'd4, 8'd1, waited);
    wait_idle("t6_idle", 80);
    exp_log.push_back({FWD, 3'd4});
    add_brake();
    check_log("t6");
    chk("t6_done", done_cnt, 1);
    repeat (8) tick();
    chk("t6_after_len", re_log.size(), exp_log.size());

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
